iob_wishbone2iob: RTL and testbench
===================================

IOB_WISHBONE2IOB -- requirements
Module: iob_wishbone2iob

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- ADDR_W, 32, address width.
- DATA_W, 32, data width; a multiple of 8.
- TIMEOUT_W, 8, timeout counter width; used only with IOB_WB2IOB_TIMEOUT_EN.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1, clock.
- arst_i, in, 1, reset: synchronous, active-high.
- wb_addr_i, in, ADDR_W, Wishbone address.
- wb_select_i, in, DATA_W/8, byte select.
- wb_we_i, in, 1, write enable.
- wb_cyc_i, in, 1, cycle.
- wb_stb_i, in, 1, strobe.
- wb_data_i, in, DATA_W, write data.
- wb_ack_o, out, 1, acknowledge.
- wb_error_o, out, 1, error.
- wb_data_o, out, DATA_W, read data.
- valid_o, out, 1, IOb request valid.
- address_o, out, ADDR_W, IOb address.
- wdata_o, out, DATA_W, IOb write data.
- wstrb_o, out, DATA_W/8, IOb write strobe; all zero means read.
- rdata_i, in, DATA_W, IOb read data.
- ready_i, in, 1, IOb ready.

Function
REQ-003 The block SHALL be a Wishbone classic slave that forwards each Wishbone access as one IOb native request.
REQ-004 The FSM SHALL have states IDLE, REQ and ACK, plus ERR when IOB_WB2IOB_TIMEOUT_EN is defined.
REQ-005 In IDLE, when wb_cyc_i & wb_stb_i = 1, the block SHALL:
- register address_o = wb_addr_i and wdata_o = wb_data_i;
- register wstrb_o = wb_select_i if wb_we_i, else 0;
- go to REQ.
REQ-006 valid_o SHALL be 1 exactly while in REQ, i.e. from the cycle after the strobe was sampled; address_o, wdata_o and wstrb_o SHALL stay stable throughout REQ.
REQ-007 An IOb request SHALL complete in the cycle where valid_o = 1 and ready_i = 1; rdata_i is sampled in that cycle.
REQ-008 On completion of a read (wstrb_o = 0), rdata_i SHALL be registered into wb_data_o; writes SHALL leave wb_data_o unchanged.
REQ-009 On completion, the FSM SHALL go to ACK if the access was not aborted (REQ-011), else to IDLE.
REQ-010 ACK SHALL assert wb_ack_o for exactly one cycle and then return to IDLE.
- Minimum strobe-to-ack latency is 2 cycles when ready_i = 1 in the first REQ cycle.
- A strobe still asserted in the first IDLE cycle after ACK SHALL start a new access (back-to-back).
REQ-011 Abort: if wb_cyc_i = 0 in any REQ cycle, an aborted flag SHALL be set.
- valid_o stays asserted until ready_i, because IOb requests cannot be withdrawn.
- No wb_ack_o or wb_error_o is issued for that access.
- The flag is cleared on entry to IDLE.
REQ-012 wb_ack_o and wb_error_o SHALL never be 1 in the same cycle, and neither SHALL be 1 outside ACK/ERR.
REQ-013 Strobes arriving while in REQ, ACK or ERR SHALL be ignored; they are not queued.

Reset
REQ-014 While arst_i = 1 at a clk_i edge, the block SHALL enter IDLE and drive to 0:
- valid_o, wb_ack_o, wb_error_o;
- address_o, wdata_o, wstrb_o, wb_data_o;
- the timeout counter and the aborted flag.
REQ-015 Reset asserted mid-REQ SHALL drop valid_o in the next cycle; the outstanding IOb request is abandoned.

Configuration
REQ-016 With macro IOB_WB2IOB_TIMEOUT_EN defined:
- A TIMEOUT_W-bit counter SHALL clear on REQ entry and increment each REQ cycle with ready_i = 0.
- When the counter reaches 2^TIMEOUT_W-1 with ready_i = 0, the FSM SHALL leave REQ (valid_o = 0 next cycle) and enter ERR.
- ERR SHALL assert wb_error_o for one cycle (suppressed if aborted), then go to IDLE.
- If ready_i = 1 in the terminal-count cycle, completion SHALL win and normal ACK follows.
REQ-017 Without IOB_WB2IOB_TIMEOUT_EN:
- No counter and no ERR state SHALL exist.
- wb_error_o SHALL be constant 0.
- REQ SHALL wait indefinitely for ready_i.

Verification
REQ-018 Read: stb at addr 0x10, we=0, ready_i=1 with rdata_i=0xDEADBEEF on the first valid cycle -> wstrb_o=0, address_o=0x10, wb_ack_o 2 cycles after stb for one cycle, wb_data_o=0xDEADBEEF.
REQ-019 Write: stb, we=1, sel=0x3, data=0x12345678, ready_i delayed 3 cycles -> valid_o high for 4 cycles, wstrb_o=0x3, wdata_o=0x12345678, one wb_ack_o, wb_data_o unchanged.
REQ-020 Abort: wb_cyc_i dropped in the second REQ cycle, ready_i at the fourth -> valid_o held 4 cycles, no ack or error, IDLE the next cycle.
REQ-021 Back-to-back: strobe held with the address changed after ack, ready_i always 1 -> second valid_o carries the new address, acks 3 cycles apart.
REQ-022 Timeout (macro on, TIMEOUT_W=4): ready_i never asserted -> valid_o drops after 15 REQ cycles, one wb_error_o pulse, no ack; with ready_i=1 at terminal count -> wb_ack_o, no error.
REQ-023 Reset: arst_i pulsed during REQ -> valid_o=0 and all outputs 0 the next cycle, a new strobe is accepted normally.

Source files
------------

// File: rtl/iob_wishbone2iob.sv
// Wishbone classic slave to IOb native bridge: one IOb request per Wishbone access.
// Define IOB_WB2IOB_TIMEOUT_EN to add a ready_i timeout that ends the access with wb_error_o.
module iob_wishbone2iob #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8
) (
  input  logic                clk_i,
  input  logic                arst_i,
  input  logic [ADDR_W-1:0]   wb_addr_i,
  input  logic [DATA_W/8-1:0] wb_select_i,
  input  logic                wb_we_i,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic [DATA_W-1:0]   wb_data_i,
  output logic                wb_ack_o,
  output logic                wb_error_o,
  output logic [DATA_W-1:0]   wb_data_o,
  output logic                valid_o,
  output logic [ADDR_W-1:0]   address_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [DATA_W/8-1:0] wstrb_o,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic                ready_i
);

`ifdef IOB_WB2IOB_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_ERR} state_t;
  localparam logic [TIMEOUT_W-1:0] C_LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);
  logic [TIMEOUT_W-1:0] r_count;
  logic                 r_err;
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK} state_t;
`endif

  state_t              r_state;
  logic                r_valid;
  logic                r_ack;
  logic                r_aborted;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic [DATA_W-1:0]   r_rdata;
  logic                w_abort;

  // An access counts as aborted if cyc has dropped in this or any earlier REQ cycle.
  assign w_abort = r_aborted | ~wb_cyc_i;

  always_ff @(posedge clk_i) begin
    if (arst_i) begin
      r_state   <= S_IDLE;
      r_valid   <= 1'b0;
      r_ack     <= 1'b0;
      r_aborted <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_rdata   <= '0;
`ifdef IOB_WB2IOB_TIMEOUT_EN
      r_count   <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_ack <= 1'b0;
`ifdef IOB_WB2IOB_TIMEOUT_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            r_addr  <= wb_addr_i;
            r_wdata <= wb_data_i;
            r_wstrb <= wb_we_i ? wb_select_i : '0;
            r_valid <= 1'b1;
            r_state <= S_REQ;
`ifdef IOB_WB2IOB_TIMEOUT_EN
            r_count <= '0;
`endif
          end
        end
        S_REQ: begin
          if (!wb_cyc_i) r_aborted <= 1'b1;
          if (ready_i) begin
            r_valid <= 1'b0;
            if (r_wstrb == '0) r_rdata <= rdata_i;
            if (w_abort) begin
              r_aborted <= 1'b0;
              r_state   <= S_IDLE;
            end else begin
              r_ack   <= 1'b1;
              r_state <= S_ACK;
            end
          end
`ifdef IOB_WB2IOB_TIMEOUT_EN
          // The count would reach all-ones this cycle: give up on the IOb side.
          else if (r_count == C_LAST) begin
            r_valid <= 1'b0;
            r_err   <= ~w_abort;
            r_state <= S_ERR;
          end else begin
            r_count <= r_count + 1'b1;
          end
`endif
        end
        S_ACK: r_state <= S_IDLE;
`ifdef IOB_WB2IOB_TIMEOUT_EN
        S_ERR: begin
          r_aborted <= 1'b0;
          r_state   <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign valid_o   = r_valid;
  assign address_o = r_addr;
  assign wdata_o   = r_wdata;
  assign wstrb_o   = r_wstrb;
  assign wb_data_o = r_rdata;
  assign wb_ack_o  = r_ack;
`ifdef IOB_WB2IOB_TIMEOUT_EN
  assign wb_error_o = r_err;
`else
  assign wb_error_o = 1'b0;
`endif

endmodule

// File: tb/tb_iob_wishbone2iob.sv
// Self-checking bench for iob_wishbone2iob: vector table, hand sequences and random transactions.
module tb_iob_wishbone2iob;

  localparam int TW = 4;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic [31:0] wb_addr_i;
  logic [3:0]  wb_select_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic [31:0] wb_data_i;
  logic        wb_ack_o;
  logic        wb_error_o;
  logic [31:0] wb_data_o;
  logic        valid_o;
  logic [31:0] address_o;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic [31:0] rdata_i;
  logic        ready_i;

  int nCompared = 0;
  int nMismatched = 0;
  logic [31:0] expData;

  iob_wishbone2iob #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_W(TW)) dut (
    .clk_i(clk_i), .arst_i(arst_i),
    .wb_addr_i(wb_addr_i), .wb_select_i(wb_select_i), .wb_we_i(wb_we_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_data_i(wb_data_i),
    .wb_ack_o(wb_ack_o), .wb_error_o(wb_error_o), .wb_data_o(wb_data_o),
    .valid_o(valid_o), .address_o(address_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
    .rdata_i(rdata_i), .ready_i(ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    int          abortAt;
    logic [3:0]  expStrb;
    logic        expAck;
    logic [31:0] expData;
  } vec_t;

  vec_t vecs[5];

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one access from IDLE; ready_i rises in REQ cycle delay+1, cyc drops from REQ cycle abortAt.
  task automatic applyStimulus(input vec_t v);
    int  k;
    bit  done;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_addr_i = v.addr; wb_we_i = v.we;
    wb_select_i = v.sel; wb_data_i = v.wdata; ready_i = 1'b0; rdata_i = $urandom;
    @(negedge clk_i);
    checkOutput("idle_valid", valid_o, 0);
    tick;
    wb_addr_i = $urandom; wb_data_i = $urandom;
    k = 1; done = 0;
    while (!done && k <= 40) begin
      wb_stb_i = 1'b0;
      wb_cyc_i = (v.abortAt != 0 && k >= v.abortAt) ? 1'b0 : 1'b1;
      ready_i  = (k == v.delay + 1);
      rdata_i  = ready_i ? v.rdata : $urandom;
      @(negedge clk_i);
      checkOutput("req_valid", valid_o, 1);
      checkOutput("req_addr", address_o, v.addr);
      checkOutput("req_wdata", wdata_o, v.wdata);
      checkOutput("req_wstrb", wstrb_o, v.expStrb);
      checkOutput("req_noack", wb_ack_o, 0);
      done = ready_i;
      tick;
      k++;
    end
    if (!done) checkOutput("req_bound", 0, 1);
    ready_i = 1'b0;
    wb_cyc_i = v.expAck;
    @(negedge clk_i);
    checkOutput("post_valid", valid_o, 0);
    checkOutput("post_ack", wb_ack_o, v.expAck);
    checkOutput("post_err", wb_error_o, 0);
    checkOutput("post_data", wb_data_o, v.expData);
    wb_cyc_i = 1'b0;
    tick;
    @(negedge clk_i);
    checkOutput("idle_ack", wb_ack_o, 0);
    checkOutput("idle_valid2", valid_o, 0);
    tick;
  endtask

  initial begin
    vec_t rv;
    time  t1;
    time  t2;
    arst_i = 1'b1; wb_addr_i = '0; wb_select_i = '0; wb_we_i = 1'b0; wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0; wb_data_i = '0; rdata_i = '0; ready_i = 1'b0;
    tick; tick;
    @(negedge clk_i);
    checkOutput("rst_valid", valid_o, 0);
    checkOutput("rst_ack", wb_ack_o, 0);
    checkOutput("rst_err", wb_error_o, 0);
    checkOutput("rst_addr", address_o, 0);
    checkOutput("rst_wdata", wdata_o, 0);
    checkOutput("rst_wstrb", wstrb_o, 0);
    checkOutput("rst_data", wb_data_o, 0);
    arst_i = 1'b0;
    tick;

    vecs[0] = '{32'h10, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF, 0, 0, 4'h0, 1'b1, 32'hDEADBEEF};
    vecs[1] = '{32'h20, 1'b1, 4'h3, 32'h12345678, 32'h0, 3, 0, 4'h3, 1'b1, 32'hDEADBEEF};
    vecs[2] = '{32'h30, 1'b1, 4'hF, 32'hA5A5A5A5, 32'h0, 3, 2, 4'hF, 1'b0, 32'hDEADBEEF};
    vecs[3] = '{32'h200, 1'b0, 4'h0, 32'h0, 32'hCAFEF00D, 2, 0, 4'h0, 1'b1, 32'hCAFEF00D};
    vecs[4] = '{32'h4, 1'b1, 4'hC, 32'h87654321, 32'h11223344, 1, 0, 4'hC, 1'b1, 32'hCAFEF00D};
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);
    expData = 32'hCAFEF00D;

    // Back-to-back reads with strobe held and ready_i always high.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 32'h100;
    ready_i = 1'b1; rdata_i = 32'h11111111;
    tick;
    @(negedge clk_i);
    checkOutput("b2b_valid1", valid_o, 1);
    checkOutput("b2b_addr1", address_o, 32'h100);
    tick;
    wb_addr_i = 32'h104; rdata_i = 32'h22222222;
    @(negedge clk_i);
    checkOutput("b2b_ack1", wb_ack_o, 1);
    checkOutput("b2b_data1", wb_data_o, 32'h11111111);
    t1 = $time;
    tick;
    @(negedge clk_i);
    checkOutput("b2b_gap_valid", valid_o, 0);
    checkOutput("b2b_gap_ack", wb_ack_o, 0);
    tick;
    @(negedge clk_i);
    checkOutput("b2b_valid2", valid_o, 1);
    checkOutput("b2b_addr2", address_o, 32'h104);
    tick;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; ready_i = 1'b0;
    @(negedge clk_i);
    checkOutput("b2b_ack2", wb_ack_o, 1);
    checkOutput("b2b_data2", wb_data_o, 32'h22222222);
    t2 = $time;
    checkOutput("b2b_spacing", 32'(t2 - t1), 32'd30);
    expData = 32'h22222222;
    tick; tick;

    // Random transactions: expectations come from the transaction-level rules.
    for (int n = 0; n < 40; n++) begin
      rv.addr  = $urandom;
      rv.we    = $urandom_range(0, 1);
      rv.sel   = 4'($urandom_range(1, 15));
      rv.wdata = $urandom;
      rv.rdata = $urandom;
      rv.delay = $urandom_range(0, 5);
      rv.abortAt = (rv.we && $urandom_range(0, 3) == 0) ? $urandom_range(1, rv.delay + 1) : 0;
      rv.expStrb = rv.we ? rv.sel : 4'h0;
      rv.expAck  = (rv.abortAt == 0);
      if (!rv.we) expData = rv.rdata;
      rv.expData = expData;
      applyStimulus(rv);
    end

    // Reset in the middle of a request.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_select_i = 4'hF;
    wb_addr_i = 32'h55; wb_data_i = 32'h99; ready_i = 1'b0;
    tick;
    wb_stb_i = 1'b0;
    tick;
    arst_i = 1'b1;
    tick;
    arst_i = 1'b0; wb_cyc_i = 1'b0;
    @(negedge clk_i);
    checkOutput("mrst_valid", valid_o, 0);
    checkOutput("mrst_addr", address_o, 0);
    checkOutput("mrst_wdata", wdata_o, 0);
    checkOutput("mrst_wstrb", wstrb_o, 0);
    checkOutput("mrst_data", wb_data_o, 0);
    checkOutput("mrst_ack", wb_ack_o, 0);
    tick;
    rv = '{32'h40, 1'b0, 4'h0, 32'h0, 32'h5A5A0001, 1, 0, 4'h0, 1'b1, 32'h5A5A0001};
    applyStimulus(rv);

`ifdef IOB_WB2IOB_TIMEOUT_EN
    // Timeout with ready_i never asserted: valid for 2^TW-1 cycles, then one error pulse.
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = 32'h80; ready_i = 1'b0;
    tick;
    wb_stb_i = 1'b0;
    for (int k = 0; k < (1 << TW) - 1; k++) begin
      @(negedge clk_i);
      checkOutput("to_valid", valid_o, 1);
      checkOutput("to_noerr", wb_error_o, 0);
      tick;
    end
    @(negedge clk_i);
    checkOutput("to_valid_drop", valid_o, 0);
    checkOutput("to_err", wb_error_o, 1);
    checkOutput("to_noack", wb_ack_o, 0);
    wb_cyc_i = 1'b0;
    tick;
    @(negedge clk_i);
    checkOutput("to_err_once", wb_error_o, 0);
    tick;
    rv = '{32'h84, 1'b0, 4'h0, 32'h0, 32'h7777AAAA, (1 << TW) - 2, 0, 4'h0, 1'b1, 32'h7777AAAA};
    applyStimulus(rv);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
